// File: rtl/bakery_ticket_arbiter_pkg.sv
// rtl/bakery_ticket_arbiter_pkg.sv - requester state encoding, default sizes and parameter legality check
package bakery_ticket_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHOOSING = 3'd1,
    ST_WAITING  = 3'd2,
    ST_CRIT     = 3'd3,
    ST_EXIT     = 3'd4
  } client_state_t;

  localparam int DEF_NPROC    = 4;
  localparam int DEF_SELW     = 2;
  localparam int DEF_TW       = 3;
  localparam int DEF_HOLD_MAX = 15;
  localparam int DEF_HW       = 4;

  // Tickets must not alias while NPROC of them are outstanding.
  function automatic bit params_legal(input int nproc, input int selw, input int tw,
                                      input int hold_max, input int hw);
    return (nproc >= 1) && ((1 << selw) >= nproc) && ((1 << tw) >= nproc) &&
           (hold_max >= 1) && ((1 << hw) > hold_max);
  endfunction

endpackage

// File: rtl/bakery_ticket_arbiter_if.sv
// rtl/bakery_ticket_arbiter_if.sv - request/release/grant bundle between clients and the bakery arbiter
interface bakery_ticket_arbiter_if
  import bakery_ticket_arbiter_pkg::*;
#(
  parameter int NPROC = DEF_NPROC,
  parameter int SELW  = DEF_SELW,
  parameter int TW    = DEF_TW
);
  logic [NPROC-1:0] req;
  logic [NPROC-1:0] rel;
  logic [NPROC-1:0] grant;
  logic [SELW-1:0]  gnt_id;
  logic             busy;
  logic [TW-1:0]    next_ticket;
  logic [TW-1:0]    serving;
  logic             timeout;

  modport master (
    output req, rel,
    input  grant, gnt_id, busy, next_ticket, serving, timeout
  );

  modport slave (
    input  req, rel,
    output grant, gnt_id, busy, next_ticket, serving, timeout
  );
endinterface

// File: rtl/bakery_client_fsm.sv
// rtl/bakery_client_fsm.sv - one requester's bakery state machine and ticket register
module bakery_client_fsm
  import bakery_ticket_arbiter_pkg::*;
#(
  parameter int TW = DEF_TW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          rel,
  input  logic          force_exit,
  input  logic          crit_busy,
  input  logic [TW-1:0] issued_ticket,
  input  logic [TW-1:0] serving,
  output logic          choosing,
  output logic          in_crit,
  output logic          crit_next
);

  client_state_t state, state_next;
  logic [TW-1:0] my_ticket;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      my_ticket <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CHOOSING) my_ticket <= issued_ticket;
    end
  end

  // Withdrawal is not supported: req is only looked at in IDLE and EXIT.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (req) state_next = ST_CHOOSING;
      ST_CHOOSING: state_next = ST_WAITING;
      ST_WAITING:  if ((my_ticket == serving) && !crit_busy) state_next = ST_CRIT;
      ST_CRIT:     if (rel || force_exit) state_next = ST_EXIT;
      ST_EXIT:     if (!req) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    choosing  = (state == ST_CHOOSING);
    in_crit   = (state == ST_CRIT);
    crit_next = (state_next == ST_CRIT);
  end

endmodule

// File: rtl/bakery_ticket_arbiter.sv
// rtl/bakery_ticket_arbiter.sv - bakery-discipline ticket arbiter; BAKERY_WATCHDOG_EN adds a hold-time revoke
module bakery_ticket_arbiter
  import bakery_ticket_arbiter_pkg::*;
#(
  parameter int NPROC    = DEF_NPROC,
  parameter int SELW     = DEF_SELW,
  parameter int TW       = DEF_TW,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int HW       = DEF_HW
) (
  input logic                     clock,
  input logic                     reset,
  bakery_ticket_arbiter_if.slave  bus
);

  if (!params_legal(NPROC, SELW, TW, HOLD_MAX, HW)) begin : g_bad_params
    $error("bakery_ticket_arbiter: illegal NPROC/SELW/TW/HOLD_MAX/HW combination");
  end

  logic [NPROC-1:0] choosing;
  logic [NPROC-1:0] in_crit;
  logic [NPROC-1:0] crit_next;
  logic [TW-1:0]    issued [NPROC];
  logic [TW-1:0]    draw_cnt;
  logic [TW-1:0]    next_ticket_q;
  logic [TW-1:0]    serving_q;
  logic [SELW-1:0]  gnt_id_d;
  logic             crit_busy;
  logic             force_exit;
  logic             holder_exit;

  for (genvar i = 0; i < NPROC; i++) begin : g_client
    bakery_client_fsm #(.TW(TW)) u_client (
      .clock         (clock),
      .reset         (reset),
      .req           (bus.req[i]),
      .rel           (bus.rel[i]),
      .force_exit    (force_exit),
      .crit_busy     (crit_busy),
      .issued_ticket (issued[i]),
      .serving       (serving_q),
      .choosing      (choosing[i]),
      .in_crit       (in_crit[i]),
      .crit_next     (crit_next[i])
    );
  end

  // Prefix count over CHOOSING bits hands out consecutive tickets, lowest index first.
  always_comb begin
    draw_cnt = '0;
    for (int i = 0; i < NPROC; i++) begin
      issued[i] = next_ticket_q + draw_cnt;
      draw_cnt  = draw_cnt + TW'(choosing[i]);
    end
  end

  always_comb begin
    gnt_id_d = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (crit_next[i]) gnt_id_d = SELW'(i);
    end
  end

  assign crit_busy   = |in_crit;
  assign holder_exit = |(in_crit & (bus.rel | {NPROC{force_exit}}));

  always_ff @(posedge clock) begin
    if (reset) begin
      next_ticket_q <= '0;
      serving_q     <= '0;
      bus.grant     <= '0;
      bus.gnt_id    <= '0;
      bus.busy      <= 1'b0;
    end else begin
      next_ticket_q <= next_ticket_q + draw_cnt;
      if (holder_exit) serving_q <= serving_q + 1'b1;
      bus.grant     <= crit_next;
      bus.gnt_id    <= gnt_id_d;
      bus.busy      <= |crit_next;
    end
  end

  assign bus.next_ticket = next_ticket_q;
  assign bus.serving     = serving_q;

`ifdef BAKERY_WATCHDOG_EN
  logic [HW-1:0] hold_cnt;
  logic          holder_rel;
  logic          timeout_q;

  // The mandatory idle cycle between holders returns the counter to zero before each entry.
  assign holder_rel = |(in_crit & bus.rel);
  assign force_exit = crit_busy && !holder_rel && (hold_cnt == HW'(HOLD_MAX - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_exit;
      if (!crit_busy || force_exit) hold_cnt <= '0;
      else                          hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_exit  = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bakery_ticket_arbiter.sv
// tb/tb_bakery_ticket_arbiter.sv - directed bench with a queue-based bakery model checked every cycle
module tb_bakery_ticket_arbiter;
  localparam int NPROC    = 4;
  localparam int SELW     = 2;
  localparam int TW       = 3;
  localparam int HOLD_MAX = 15;
  localparam int HW       = 4;
  localparam int TMOD     = 1 << TW;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  bakery_ticket_arbiter_if #(.NPROC(NPROC), .SELW(SELW), .TW(TW)) bus ();

  bakery_ticket_arbiter #(
    .NPROC(NPROC), .SELW(SELW), .TW(TW), .HOLD_MAX(HOLD_MAX), .HW(HW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model: a FIFO of ticket holders in draw order, plus who is idle, drawing or exiting.
  int             m_holder = -1;
  int             m_held = 0;
  int             m_serving = 0;
  int             m_next = 0;
  bit             m_timeout = 0;
  bit [NPROC-1:0] m_idle = '1;
  bit [NPROC-1:0] m_drawing = '0;
  bit [NPROC-1:0] m_exiting = '0;
  int             line[$];
  bit             model_valid = 0;
  int             timeouts_seen = 0;
  int             gnt_log[$];
  logic [NPROC-1:0] prev_grant = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [NPROC-1:0] rq, input logic [NPROC-1:0] rl, input logic rs);
    bit [NPROC-1:0] new_draw;
    bit fired;
    new_draw = '0;
    m_timeout = 0;
    if (rs) begin
      m_holder = -1; m_held = 0; m_serving = 0; m_next = 0;
      m_idle = '1; m_drawing = '0; m_exiting = '0;
      line.delete();
      return;
    end
    for (int i = 0; i < NPROC; i++)
      if (m_idle[i] && rq[i]) begin new_draw[i] = 1; m_idle[i] = 0; end
    for (int i = 0; i < NPROC; i++)
      if (m_exiting[i] && !rq[i]) begin m_exiting[i] = 0; m_idle[i] = 1; end
    if (m_holder >= 0) begin
      fired = rl[m_holder];
`ifdef BAKERY_WATCHDOG_EN
      if (!fired && m_held == HOLD_MAX) begin fired = 1; m_timeout = 1; end
`endif
      if (fired) begin
        m_exiting[m_holder] = 1;
        m_holder = -1;
        m_serving = (m_serving + 1) % TMOD;
      end else begin
        m_held++;
      end
    end else if (line.size() > 0) begin
      m_holder = line.pop_front();
      m_held = 1;
    end
    for (int i = 0; i < NPROC; i++)
      if (m_drawing[i]) begin line.push_back(i); m_next = (m_next + 1) % TMOD; end
    m_drawing = new_draw;
  endtask

  always @(posedge clock) begin
    model_step(bus.req, bus.rel, reset);
    model_valid = 1;
  end

  always @(negedge clock) begin
    if (model_valid) begin
      chk("grant", int'(bus.grant), (m_holder >= 0) ? (1 << m_holder) : 0);
      chk("gnt_id", int'(bus.gnt_id), (m_holder >= 0) ? m_holder : 0);
      chk("busy", int'(bus.busy), (m_holder >= 0) ? 1 : 0);
      chk("next_ticket", int'(bus.next_ticket), m_next);
      chk("serving", int'(bus.serving), m_serving);
      chk("timeout", int'(bus.timeout), int'(m_timeout));
      chk("grant_onehot", int'($countones(bus.grant) <= 1), 1);
      if (bus.timeout) timeouts_seen++;
      if (bus.grant != '0 && prev_grant == '0) gnt_log.push_back(int'(bus.gnt_id));
      prev_grant = bus.grant;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_req(input logic [NPROC-1:0] m);
    bus.req = m;
    step(1);
    bus.req = '0;
  endtask

  task automatic pulse_rel(input int idx);
    bus.rel = '0;
    bus.rel[idx] = 1'b1;
    step(1);
    bus.rel = '0;
  endtask

  task automatic wait_grant(input int idx, input int budget);
    int n;
    n = 0;
    while (!bus.grant[idx] && n < budget) begin
      step(1);
      n++;
    end
    chk($sformatf("wait_grant%0d", idx), int'(bus.grant[idx]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp_order[3];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3;
    reset = 1'b1;
    bus.req = '0;
    bus.rel = '0;
    step(2);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_next", int'(bus.next_ticket), 0);
    chk("rst_serving", int'(bus.serving), 0);
    reset = 1'b0;
    step(1);

    // Single requester: minimum latency then release.
    bus.req = 4'b0100;
    step(1);
    bus.req = '0;
    step(2);
    chk("s1_grant", int'(bus.grant), 4);
    chk("s1_gnt_id", int'(bus.gnt_id), 2);
    chk("s1_serving", int'(bus.serving), 0);
    chk("s1_next", int'(bus.next_ticket), 1);
    pulse_rel(2);
    chk("s1_rel_grant", int'(bus.grant), 0);
    chk("s1_rel_serving", int'(bus.serving), 1);
    step(1);

    // Simultaneous draw: order 0,1,3 with one idle grant cycle between holders.
    gnt_log.delete();
    pulse_req(4'b1011);
    wait_grant(0, 8);
    step(1);
    pulse_rel(0);
    chk("s2_gap", int'(bus.grant), 0);
    step(1);
    chk("s2_second", int'(bus.grant), 2);
    pulse_rel(1);
    wait_grant(3, 8);
    pulse_rel(3);
    step(2);
    chk("s2_log_len", gnt_log.size(), 3);
    for (int k = 0; k < 3 && k < gnt_log.size(); k++)
      chk($sformatf("s2_order%0d", k), gnt_log[k], exp_order[k]);
    chk("s2_next", int'(bus.next_ticket), 4);
    chk("s2_serving", int'(bus.serving), 4);

    // Ten back-to-back single transactions wrap both counters.
    for (int k = 0; k < 10; k++) begin
      pulse_req(4'(1 << (k % NPROC)));
      wait_grant(k % NPROC, 8);
      pulse_rel(k % NPROC);
      step(1);
    end
    chk("s3_serving", int'(bus.serving), 6);
    chk("s3_next", int'(bus.next_ticket), 6);

    // Release and a new draw in the same cycle.
    pulse_req(4'b0001);
    wait_grant(0, 8);
    bus.rel = 4'b0001;
    bus.req = 4'b0010;
    step(1);
    bus.rel = '0;
    bus.req = '0;
    chk("s4_serving", int'(bus.serving), 7);
    wait_grant(1, 8);
    chk("s4_gnt_id", int'(bus.gnt_id), 1);
    chk("s4_next", int'(bus.next_ticket), 0);
    pulse_rel(1);
    step(1);
    pulse_rel(2);
    step(1);
    chk("s4_stray_rel", int'(bus.serving), 0);

    // Held req after release stays out; then reset in the middle of a grant.
    bus.req = 4'b1000;
    wait_grant(3, 8);
    pulse_rel(3);
    step(4);
    chk("s5_no_redraw", int'(bus.next_ticket), 1);
    chk("s5_no_regrant", int'(bus.grant), 0);
    bus.req = '0;
    step(1);
    pulse_req(4'b1000);
    wait_grant(3, 8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("s5_rst_grant", int'(bus.grant), 0);
    chk("s5_rst_id", int'(bus.gnt_id), 0);
    chk("s5_rst_next", int'(bus.next_ticket), 0);
    pulse_req(4'b1000);
    wait_grant(3, 8);
    chk("s5_serving", int'(bus.serving), 0);
    chk("s5_next", int'(bus.next_ticket), 1);
    pulse_rel(3);
    step(2);

    // Holder that never releases.
    timeouts_seen = 0;
    pulse_req(4'b0011);
    wait_grant(0, 8);
`ifdef BAKERY_WATCHDOG_EN
    wait_grant(1, 40);
    chk("s6_timeouts", timeouts_seen, 1);
    pulse_rel(1);
`else
    step(20);
    chk("s6_still_held", int'(bus.grant), 1);
    pulse_rel(0);
    wait_grant(1, 8);
    pulse_rel(1);
    chk("s6_timeouts", timeouts_seen, 0);
`endif
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bakery_ticket_arbiter.md
Name: bakery_ticket_arbiter

Overview:
- Hardware arbiter granting one shared critical resource to NPROC requesters under bakery-algorithm discipline.
- Each requester draws a numbered ticket; the grant goes to the holder of the "now serving" number.
- Simultaneous draws are ordered by fixed index priority: lower index receives the lower ticket.
- Sits between client processes and the shared resource; it is the synthesizable controller counterpart of the bakery mutual-exclusion model.

Parameters:
- NPROC, 4, number of requesters, indices 0..NPROC-1.
- SELW, 2, width of a process index; requires 2**SELW >= NPROC.
- TW, 3, ticket width; requires 2**TW >= NPROC.
- HOLD_MAX, 15, maximum grant hold in cycles (optional feature only).
- HW, 4, hold counter width; requires 2**HW > HOLD_MAX.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high.
- req, input, NPROC, per-requester request level.
- release, input, NPROC, per-requester release pulse.
- grant, output, NPROC, registered; one-hot or zero.
- gnt_id, output, SELW, index of current holder; 0 when idle.
- busy, output, 1, high while any grant is high.
- next_ticket, output, TW, next ticket to be issued.
- serving, output, TW, ticket currently being served.
- timeout, output, 1, one-cycle pulse on forced revoke; tied 0 without the optional feature.

Behaviour:
- Interface (already decided): one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: every requester FSM to IDLE; grant=0, gnt_id=0, busy=0, next_ticket=0, serving=0, timeout=0; all stored tickets=0. Reset mid-operation drops any grant at the next edge.
- Per-requester FSM states: IDLE, CHOOSING, WAITING, CRIT, EXIT.
  - IDLE: req=1 -> CHOOSING.
  - CHOOSING: ticket latched -> WAITING. Never stays more than one cycle.
  - WAITING: my_ticket==serving and no requester in CRIT -> CRIT; grant bit rises with this transition.
  - CRIT: release=1 -> EXIT; grant falls at the same edge; serving <= serving+1 mod 2**TW.
  - EXIT: req=0 -> IDLE; req held high -> stay in EXIT (no re-entry without a req low cycle).
- Ticket issue: all requesters in CHOOSING in one cycle receive consecutive tickets next_ticket, next_ticket+1, ... in ascending index order; next_ticket advances by that count, mod 2**TW.
- Minimum latency: req rising at edge n gives CHOOSING after n, WAITING after n+1, grant high after n+2 when the ticket is being served.
- Request withdrawal is not supported: req low in CHOOSING/WAITING is ignored.
- Ignored inputs: release outside CRIT; req in CRIT.
- Simultaneous events: a release and new CHOOSING entries in the same cycle are both applied. The next holder is granted no earlier than one cycle after the release edge (one idle grant cycle between holders).
- Invariants: popcount(grant) <= 1; grant order equals ticket order; every WAITING requester is granted within NPROC grant periods.
- gnt_id and busy are registered alongside grant.

Optional Feature:
- Macro: BAKERY_WATCHDOG_EN.
- Defined: a hold counter clears on entry to CRIT and increments each CRIT cycle. When it reaches HOLD_MAX with no release, the holder is forced to EXIT exactly as if released (grant falls, serving advances) and timeout pulses high for one cycle. A release in the same cycle takes precedence and no timeout pulse is produced.
- Undefined: no counter is built; timeout is constant 0; a grant is held indefinitely.

Decomposition:
- Shared package/include: state enum (IDLE, CHOOSING, WAITING, CRIT, EXIT) and the parameter legality checks.
- Sub-module bakery_client_fsm, instantiated NPROC times. Holds one requester's state and ticket register; takes its issued ticket, serving, and a global "crit_busy" as inputs.
- The top level owns: ticket dispenser (prefix count of CHOOSING bits), serving counter, grant/gnt_id encoding, and the watchdog.

Test Plan:
- Single requester: req[2]=1 at cycle 0 -> grant=4'b0100 after edge 2, gnt_id=2, serving=0; release pulse -> grant=0, serving=1, next_ticket=1.
- Simultaneous draw: req=4'b1011 in the same cycle -> tickets 0,1,2 to idx 0,1,3; grants in order 0,1,3 with one idle cycle between holders.
- Wraparound: TW=3, 10 back-to-back single-requester transactions -> serving and next_ticket wrap 7->0; grants continue correctly.
- Release plus new draw in one cycle: holder idx0 releases while idx1 enters CHOOSING -> serving advances and idx1 gets its ticket; idx1 is granted once the ticket is served.
- Reset mid-CRIT: reset during grant to idx3 -> all outputs 0 after the edge; a subsequent req[3] starts from ticket 0.
- Watchdog (macro defined): holder never releases -> grant drops after HOLD_MAX=15 CRIT cycles, timeout pulses once, next waiter is granted. Macro undefined -> timeout stays 0 throughout.
